// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, reads instruction memory over a req/ready handshake,
// holds the fetched word in the IR, and steps the PC when the datapath retires the instruction.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 32
) (
  input  logic             clk,
  input  logic             reset,
  output logic             imem_req,
  output logic [31:0]      imem_addr,
  input  logic             imem_ready,
  input  logic [31:0]      imem_rdata,
  output logic [31:0]      instr,
  output logic             instr_valid,
  output logic [5:0]       op,
  output logic [5:0]       func,
  output logic [31:0]      pc,
  output logic [31:0]      pc_plus4,
  input  logic             advance,
  input  logic             pcsrc,
  input  logic [31:0]      branch_off,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic {S_FETCH, S_EXEC} state_t;

  state_t           r_state;
  logic [31:0]      r_pc;
  logic [31:0]      r_instr;
  logic             r_valid;
  logic [CNT_W-1:0] r_retired;

  logic [31:0] w_pc_plus4;
  logic [31:0] w_branch_tgt;
  logic [31:0] w_next_pc;
  logic        w_fetch_done;
  logic        w_unused;

  assign w_pc_plus4   = r_pc + 32'd4;
  // Word offset scaled to bytes; the top two offset bits fall off the 32-bit result.
  assign w_branch_tgt = w_pc_plus4 + {branch_off[29:0], 2'b00};
  assign w_next_pc    = pcsrc ? w_branch_tgt : w_pc_plus4;
  assign w_fetch_done = (r_state == S_FETCH) && imem_ready;
  assign w_unused     = ^branch_off[31:30];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_FETCH;
      r_pc      <= {RESET_PC[31:2], 2'b00};
      r_instr   <= 32'd0;
      r_valid   <= 1'b0;
      r_retired <= '0;
    end else begin
      case (r_state)
        S_FETCH: begin
          if (w_fetch_done) begin
            r_instr <= imem_rdata;
            r_valid <= 1'b1;
            r_state <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (advance) begin
            r_pc      <= w_next_pc;
            r_valid   <= 1'b0;
            r_retired <= r_retired + CNT_W'(1);
            r_state   <= S_FETCH;
          end
        end
        default: r_state <= S_FETCH;
      endcase
    end
  end

  // Reset gates the request combinationally so an in-flight access is dropped in the reset cycle.
  assign imem_req    = (r_state == S_FETCH) && !reset;
  assign imem_addr   = r_pc;
  assign instr       = r_instr;
  assign instr_valid = r_valid;
  assign op          = r_instr[31:26];
  assign func        = r_instr[5:0];
  assign pc          = r_pc;
  assign pc_plus4    = w_pc_plus4;
  assign retired     = r_retired;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: a hand-derived cycle table for the corner cases, then randomized
// handshake/branch traffic checked against an instruction-level reference model.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic        instr_valid;
  logic [5:0]  op;
  logic [5:0]  func;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        advance;
  logic        pcsrc;
  logic [31:0] branch_off;
  logic [31:0] retired;

  logic        use_fn;
  logic [31:0] rdata_drv;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  assign imem_rdata = use_fn ? mem_fn(imem_addr) : rdata_drv;

  fetch_unit #(.RESET_PC(32'h0000_0000), .CNT_W(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ready (imem_ready),
    .imem_rdata (imem_rdata),
    .instr      (instr),
    .instr_valid(instr_valid),
    .op         (op),
    .func       (func),
    .pc         (pc),
    .pc_plus4   (pc_plus4),
    .advance    (advance),
    .pcsrc      (pcsrc),
    .branch_off (branch_off),
    .retired    (retired)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp, input int cyc);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  typedef struct {
    logic        rst, rdy, adv, psrc;
    logic [31:0] off, rdata;
    logic        chk;
    logic        e_req, e_valid;
    logic [31:0] e_instr, e_pc, e_ret;
  } vec_t;

  function automatic vec_t v(input logic rst, rdy, adv, psrc, input logic [31:0] off, rdata,
                             input logic chk, e_req, e_valid,
                             input logic [31:0] e_instr, e_pc, e_ret);
    vec_t r;
    r.rst = rst; r.rdy = rdy; r.adv = adv; r.psrc = psrc; r.off = off; r.rdata = rdata;
    r.chk = chk; r.e_req = e_req; r.e_valid = e_valid;
    r.e_instr = e_instr; r.e_pc = e_pc; r.e_ret = e_ret;
    return r;
  endfunction

  vec_t vecs[26];

  // Instruction-level reference state
  logic [31:0] m_pc, m_instr, m_ret;
  bit          m_holding;

  initial begin
    use_fn = 1'b0; rdata_drv = 32'd0;
    reset = 1'b1; imem_ready = 1'b0; advance = 1'b0; pcsrc = 1'b0; branch_off = 32'd0;

    //            rst rdy adv ps off           rdata          chk req val instr          pc             ret
    vecs[0]  = v(1, 1, 0, 0, 32'h0,        32'h0,         0, 0, 0, 32'h0,        32'h0,         0);
    vecs[1]  = v(1, 1, 0, 0, 32'h0,        32'h0,         1, 0, 0, 32'h0,        32'h0,         0);
    vecs[2]  = v(0, 1, 0, 0, 32'h0,        32'h8C01_0004, 1, 1, 0, 32'h0,        32'h0,         0);
    vecs[3]  = v(0, 1, 0, 0, 32'h0,        32'h0,         1, 0, 1, 32'h8C01_0004, 32'h0,        0);
    vecs[4]  = v(0, 0, 1, 0, 32'h100,      32'h0,         1, 0, 1, 32'h8C01_0004, 32'h0,        0);
    vecs[5]  = v(0, 0, 1, 1, 32'h40,       32'h1111_1111, 1, 1, 0, 32'h8C01_0004, 32'h4,        1);
    vecs[6]  = v(0, 0, 0, 0, 32'h0,        32'h1111_1111, 1, 1, 0, 32'h8C01_0004, 32'h4,        1);
    vecs[7]  = v(0, 0, 0, 0, 32'h0,        32'h1111_1111, 1, 1, 0, 32'h8C01_0004, 32'h4,        1);
    vecs[8]  = v(0, 1, 0, 0, 32'h0,        32'h0000_0020, 1, 1, 0, 32'h8C01_0004, 32'h4,        1);
    vecs[9]  = v(0, 0, 1, 1, 32'h1,        32'h0,         1, 0, 1, 32'h0000_0020, 32'h4,        1);
    vecs[10] = v(0, 1, 0, 0, 32'h0,        32'h1234_5678, 1, 1, 0, 32'h0000_0020, 32'hC,        2);
    vecs[11] = v(0, 0, 1, 0, 32'h0,        32'h0,         1, 0, 1, 32'h1234_5678, 32'hC,        2);
    vecs[12] = v(0, 1, 0, 0, 32'h0,        32'hAABB_CCDD, 1, 1, 0, 32'h1234_5678, 32'h10,       3);
    vecs[13] = v(0, 0, 1, 1, 32'hFFFF_FFFE, 32'h0,        1, 0, 1, 32'hAABB_CCDD, 32'h10,       3);
    vecs[14] = v(0, 1, 0, 0, 32'h0,        32'h0BAD_F00D, 1, 1, 0, 32'hAABB_CCDD, 32'hC,        4);
    vecs[15] = v(0, 0, 1, 1, 32'h7FFF_FFFB, 32'h0,        1, 0, 1, 32'h0BAD_F00D, 32'hC,        4);
    vecs[16] = v(0, 1, 0, 0, 32'h0,        32'hFC00_0000, 1, 1, 0, 32'h0BAD_F00D, 32'hFFFF_FFFC, 5);
    vecs[17] = v(0, 0, 1, 0, 32'h0,        32'h0,         1, 0, 1, 32'hFC00_0000, 32'hFFFF_FFFC, 5);
    vecs[18] = v(0, 0, 1, 1, 32'h5,        32'h0,         1, 1, 0, 32'hFC00_0000, 32'h0,        6);
    vecs[19] = v(0, 1, 0, 0, 32'h0,        32'h0000_0001, 1, 1, 0, 32'hFC00_0000, 32'h0,        6);
    vecs[20] = v(0, 0, 1, 0, 32'h0,        32'h0,         1, 0, 1, 32'h0000_0001, 32'h0,        6);
    vecs[21] = v(0, 0, 1, 1, 32'h9,        32'h0,         1, 1, 0, 32'h0000_0001, 32'h4,        7);
    vecs[22] = v(1, 1, 1, 0, 32'h0,        32'hDEAD_BEEF, 1, 0, 0, 32'h0000_0001, 32'h4,        7);
    vecs[23] = v(0, 0, 0, 0, 32'h0,        32'h0,         1, 1, 0, 32'h0,        32'h0,         0);
    vecs[24] = v(0, 1, 0, 0, 32'h0,        32'h8C01_0004, 1, 1, 0, 32'h0,        32'h0,         0);
    vecs[25] = v(0, 0, 0, 0, 32'h0,        32'h0,         1, 0, 1, 32'h8C01_0004, 32'h0,        0);

    for (int i = 0; i < 26; i++) begin
      @(posedge clk); #1;
      reset = vecs[i].rst; imem_ready = vecs[i].rdy; advance = vecs[i].adv;
      pcsrc = vecs[i].psrc; branch_off = vecs[i].off; rdata_drv = vecs[i].rdata;
      @(negedge clk);
      if (vecs[i].chk) begin
        check("tbl_req",     {31'd0, imem_req},    {31'd0, vecs[i].e_req},   i);
        check("tbl_valid",   {31'd0, instr_valid}, {31'd0, vecs[i].e_valid}, i);
        check("tbl_instr",   instr,     vecs[i].e_instr, i);
        check("tbl_op",      {26'd0, op},   {26'd0, vecs[i].e_instr[31:26]}, i);
        check("tbl_func",    {26'd0, func}, {26'd0, vecs[i].e_instr[5:0]},   i);
        check("tbl_pc",      pc,        vecs[i].e_pc, i);
        check("tbl_addr",    imem_addr, vecs[i].e_pc, i);
        check("tbl_pc4",     pc_plus4,  vecs[i].e_pc + 32'd4, i);
        check("tbl_retired", retired,   vecs[i].e_ret, i);
      end
    end

    // Randomized traffic: first cycle is a reset so the model starts in step with the DUT.
    use_fn = 1'b1;
    m_pc = 32'd0; m_instr = 32'd0; m_ret = 32'd0; m_holding = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      reset      = (c == 0) || ($urandom_range(0, 99) == 0);
      imem_ready = $urandom_range(0, 1) == 1;
      advance    = $urandom_range(0, 9) < 4;
      pcsrc      = $urandom_range(0, 1) == 1;
      case ($urandom_range(0, 3))
        0:       branch_off = $urandom;
        1:       branch_off = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
        default: branch_off = 32'($urandom_range(0, 63));
      endcase
      @(negedge clk);
      if (c > 0) begin
        check("rnd_retired", retired, m_ret, c);
        check("rnd_pc", pc, m_pc, c);
      end
      if (reset) begin
        check("rnd_req_rst", {31'd0, imem_req}, 32'd0, c);
        m_pc = 32'd0; m_instr = 32'd0; m_ret = 32'd0; m_holding = 1'b0;
      end else if (!m_holding) begin
        check("rnd_req",   {31'd0, imem_req},    32'd1, c);
        check("rnd_addr",  imem_addr,            m_pc,  c);
        check("rnd_valid", {31'd0, instr_valid}, 32'd0, c);
        if (imem_ready) begin
          m_instr   = mem_fn(m_pc);
          m_holding = 1'b1;
        end
      end else begin
        check("rnd_req",   {31'd0, imem_req},    32'd0, c);
        check("rnd_valid", {31'd0, instr_valid}, 32'd1, c);
        check("rnd_instr", instr, m_instr, c);
        check("rnd_opfn",  {20'd0, op, func}, {20'd0, m_instr[31:26], m_instr[5:0]}, c);
        if (advance) begin
          m_pc      = m_pc + 32'd4 + (pcsrc ? branch_off * 32'd4 : 32'd0);
          m_ret     = m_ret + 32'd1;
          m_holding = 1'b0;
        end
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
